fp_div_iter: RTL and testbench

Iterative IEEE-754 single-precision divider: the counterpart of the team's combinational FP multiplier, producing `a / b`. It uses a radix-2 restoring mantissa divider, one quotient bit per cycle, behind valid/ready handshakes on both sides. Its flag semantics, rounding rule and result-priority rules match the multiplier, so the two operate as a matched pair in the FP datapath.

---
 rtl/fp_div_pkg.sv | 30 +++
 rtl/fp_div_pack.sv | 52 +++++
 rtl/fp_div_iter.sv | 185 ++++++++++++++++++
 tb/tb_fp_div_iter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared definitions for the iterative binary32 divider: FSM states, format
// constants and field-extraction helpers common to the FP multiplier.
package fp_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_PACK = 2'd2,
        ST_DONE = 2'd3
    } fp_state_e;

    localparam int FP_BIAS    = 127;
    localparam int FP_EXP_MAX = 255;
    localparam int FP_QBITS   = 26;
    localparam int FP_EXPW    = 10;

    function automatic logic fp_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [7:0] fp_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    // Denormals are flushed, so the hidden bit is always set.
    function automatic logic [23:0] fp_man(input logic [31:0] x);
        return {1'b1, x[22:0]};
    endfunction

endpackage

// File: rtl/fp_div_pack.sv
// Combinational back end of the divider: normalise, round, compute the
// biased exponent, raise overflow/underflow and select the packed result.
module fp_div_pack
    import fp_div_pkg::*;
(
    input  logic                sign,
    input  logic [7:0]          exp_a,
    input  logic [7:0]          exp_b,
    input  logic [FP_QBITS-1:0] quot,
    input  logic                rem_nz,
    output logic [31:0]         res,
    output logic                overflow,
    output logic                underflow
);

    logic                      norm_s;
    logic [22:0]               man_s;
    logic [22:0]               man_rnd_s;
    logic                      guard_s;
    logic                      sticky_s;
    logic signed [FP_EXPW-1:0] exp_s;

    // Normalise, round (carry out dropped to match the multiplier) and select.
    always_comb begin
        norm_s    = quot[FP_QBITS-1];
        man_s     = 23'd0;
        guard_s   = 1'b0;
        sticky_s  = 1'b0;
        res       = 32'd0;
        if (norm_s) begin
            man_s    = quot[24:2];
            guard_s  = quot[1];
            sticky_s = quot[0] | rem_nz;
        end else begin
            man_s    = quot[23:1];
            guard_s  = quot[0];
            sticky_s = rem_nz;
        end
        man_rnd_s = man_s + {22'd0, guard_s & sticky_s};
        exp_s     = {2'b00, exp_a} - {2'b00, exp_b} + 10'(FP_BIAS - 1) + {9'd0, norm_s};
        overflow  = (exp_s >= 10'sd255);
        underflow = (exp_s <= 10'sd0);
        if (overflow) begin
            res = {sign, 8'hFF, 23'd0};
        end else if (underflow) begin
            res = {sign, 31'd0};
        end else begin
            res = {sign, exp_s[7:0], man_rnd_s};
        end
    end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative binary32 divider (a / b), radix-2 restoring, one quotient bit per
// cycle. Define FP_DIV_BACK2BACK_EN to accept a new operation while retiring.
module fp_div_iter
    import fp_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] res,
    output logic        exception,
    output logic        overflow,
    output logic        underflow
);

    fp_state_e           state_r;
    fp_state_e           state_nxt_s;
    logic [4:0]          cnt_r;
    logic                sign_r;
    logic [7:0]          exp_a_r;
    logic [7:0]          exp_b_r;
    logic [23:0]         div_r;
    logic [24:0]         rem_r;
    logic [FP_QBITS-1:0] quot_r;
    logic [31:0]         res_r;
    logic                exception_r;
    logic                overflow_r;
    logic                underflow_r;

    logic                in_ready_s;
    logic                accept_s;
    logic                is_exc_s;
    logic                is_zero_s;
    logic                special_s;
    logic                qbit_s;
    logic [23:0]         diff_s;
    logic [24:0]         rem_nxt_s;
    logic [31:0]         pack_res_s;
    logic                pack_ovf_s;
    logic                pack_unf_s;

    assign accept_s  = in_valid & in_ready_s;
    assign is_exc_s  = (fp_exp(a) == 8'(FP_EXP_MAX)) | (fp_exp(b) == 8'(FP_EXP_MAX)) |
                       (fp_exp(b) == 8'd0);
    assign is_zero_s = (fp_exp(a) == 8'd0);
    assign special_s = is_exc_s | is_zero_s;

    assign in_ready  = in_ready_s;
    assign out_valid = (state_r == ST_DONE);
    assign res       = res_r;
    assign exception = exception_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

    // Ready decode from the state register.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: in_ready_s = 1'b1;
`ifdef FP_DIV_BACK2BACK_EN
            ST_DONE: in_ready_s = out_ready;
`endif
            default: in_ready_s = 1'b0;
        endcase
    end

    // One restoring step; the true difference always fits in 24 bits.
    always_comb begin
        qbit_s    = (rem_r >= {1'b0, div_r});
        diff_s    = rem_r[23:0] - div_r;
        rem_nxt_s = 25'd0;
        if (qbit_s) begin
            rem_nxt_s = {diff_s, 1'b0};
        end else begin
            rem_nxt_s = {rem_r[23:0], 1'b0};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = special_s ? ST_DONE : ST_DIV;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (cnt_r == 5'd25) begin
                    state_nxt_s = ST_PACK;
                end else begin
                    state_nxt_s = ST_DIV;
                end
            end
            ST_PACK: state_nxt_s = ST_DONE;
            ST_DONE: begin
                if (!out_ready) begin
                    state_nxt_s = ST_DONE;
                end else if (accept_s) begin
                    state_nxt_s = special_s ? ST_DONE : ST_DIV;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Operand capture on accept and mantissa iteration during DIV.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= 5'd0;
            sign_r  <= 1'b0;
            exp_a_r <= 8'd0;
            exp_b_r <= 8'd0;
            div_r   <= 24'd0;
            rem_r   <= 25'd0;
            quot_r  <= {FP_QBITS{1'b0}};
        end else if (accept_s) begin
            cnt_r   <= 5'd0;
            sign_r  <= fp_sign(a) ^ fp_sign(b);
            exp_a_r <= fp_exp(a);
            exp_b_r <= fp_exp(b);
            div_r   <= fp_man(b);
            rem_r   <= {1'b0, fp_man(a)};
            quot_r  <= {FP_QBITS{1'b0}};
        end else if (state_r == ST_DIV) begin
            cnt_r   <= (cnt_r == 5'd25) ? cnt_r : cnt_r + 5'd1;
            rem_r   <= rem_nxt_s;
            quot_r  <= {quot_r[FP_QBITS-2:0], qbit_s};
        end
    end

    fp_div_pack u_pack (
        .sign      (sign_r),
        .exp_a     (exp_a_r),
        .exp_b     (exp_b_r),
        .quot      (quot_r),
        .rem_nz    (|rem_r),
        .res       (pack_res_s),
        .overflow  (pack_ovf_s),
        .underflow (pack_unf_s)
    );

    // Result registers: special cases load at accept, normal results in PACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_r       <= 32'd0;
            exception_r <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (accept_s && is_exc_s) begin
            res_r       <= 32'd0;
            exception_r <= 1'b1;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (accept_s && is_zero_s) begin
            res_r       <= {fp_sign(a) ^ fp_sign(b), 31'd0};
            exception_r <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (state_r == ST_PACK) begin
            res_r       <= pack_res_s;
            exception_r <= 1'b0;
            overflow_r  <= pack_ovf_s;
            underflow_r <= pack_unf_s;
        end
    end

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed bench for fp_div_iter: vector table plus backpressure, reset and
// streaming sequences. Stream gap expectation follows FP_DIV_BACK2BACK_EN.
module tb_fp_div_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] res;
    logic        exception;
    logic        overflow;
    logic        underflow;

    int n_applied = 0;
    int n_miscompares = 0;

`ifdef FP_DIV_BACK2BACK_EN
    localparam int STREAM_GAP = 28;
`else
    localparam int STREAM_GAP = 29;
`endif
    localparam int NV = 10;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        logic        ovf;
        logic        unf;
        int          lat;
    } vec_t;

    vec_t vecs [NV];

    fp_div_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .exception (exception),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input string name, input logic [31:0] va,
                           input logic [31:0] vb, input logic [31:0] vr, input logic ve,
                           input logic vo, input logic vu, input int vl);
        vecs[i].name = name;
        vecs[i].a    = va;
        vecs[i].b    = vb;
        vecs[i].res  = vr;
        vecs[i].exc  = ve;
        vecs[i].ovf  = vo;
        vecs[i].unf  = vu;
        vecs[i].lat  = vl;
    endtask

    // Present operands, wait for ready, return just after the accept edge.
    task automatic start_op(input logic [31:0] va, input logic [31:0] vb, output bit ok);
        int guard = 0;
        @(negedge clk);
        a = va;
        b = vb;
        in_valid = 1'b1;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        ok = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 32'hDEADBEEF;
        b = 32'h12345678;
    endtask

    // Count edges after accept until out_valid, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        bit       ok;
        int       lat;
        int       n_acc;
        int       cyc;
        int       acc_t [4];
        bit       seen;

        set_vec(0, "6/2",       32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0, 27);
        set_vec(1, "1/3",       32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0, 1'b0, 27);
        set_vec(2, "div0",      32'hBF800000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 0);
        set_vec(3, "negzero",   32'h80000000, 32'h40A00000, 32'h80000000, 1'b0, 1'b0, 1'b0, 0);
        set_vec(4, "ovf",       32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 1'b1, 1'b0, 27);
        set_vec(5, "unf",       32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 27);
        set_vec(6, "nan_a",     32'h7FC00000, 32'h3F800000, 32'h00000000, 1'b1, 1'b0, 1'b0, 0);
        set_vec(7, "2/2",       32'h40000000, 32'h40000000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 27);
        set_vec(8, "1/-1.5",    32'h3F800000, 32'hBFC00000, 32'hBF2AAAAB, 1'b0, 1'b0, 1'b0, 27);
        set_vec(9, "maxman/1",  32'h3FFFFFFF, 32'h3F800000, 32'h3FFFFFFF, 1'b0, 1'b0, 1'b0, 27);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst res", res, 32'd0);
        check("rst flags", {29'd0, exception, overflow, underflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table.
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            start_op(vecs[i].a, vecs[i].b, ok);
            check({vecs[i].name, " accept"}, {31'd0, ok}, 32'd1);
            wait_done(lat);
            check({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].lat));
            check({vecs[i].name, " res"}, res, vecs[i].res);
            check({vecs[i].name, " exception"}, {31'd0, exception}, {31'd0, vecs[i].exc});
            check({vecs[i].name, " overflow"}, {31'd0, overflow}, {31'd0, vecs[i].ovf});
            check({vecs[i].name, " underflow"}, {31'd0, underflow}, {31'd0, vecs[i].unf});
            @(posedge clk);
            #1;
            check({vecs[i].name, " retire"}, {31'd0, out_valid}, 32'd0);
        end

        // Backpressure: DONE holds with stable result.
        out_ready = 1'b0;
        start_op(32'h40C00000, 32'h40000000, ok);
        wait_done(lat);
        check("bp latency", 32'(lat), 32'd27);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("bp res", res, 32'h40400000);
            check("bp in_ready", {31'd0, in_ready}, 32'd0);
            check("bp out_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release", {31'd0, out_valid}, 32'd0);

        // Reset mid-DIV drops the operation.
        start_op(32'h40C00000, 32'h40000000, ok);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst in_ready", {31'd0, in_ready}, 32'd1);
        check("mid rst out_valid", {31'd0, out_valid}, 32'd0);
        check("mid rst res", res, 32'd0);
        @(posedge clk);
        #1;
        check("mid rst idle", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("mid rst stale", {31'd0, seen}, 32'd0);
        start_op(32'h3F800000, 32'h40400000, ok);
        wait_done(lat);
        check("post rst res", res, 32'h3EAAAAAB);
        @(posedge clk);
        #1;

        // Streaming: spacing between accept edges.
        for (int k = 0; k < 4; k++) acc_t[k] = 0;
        n_acc = 0;
        cyc = 0;
        a = 32'h40C00000;
        b = 32'h40000000;
        in_valid = 1'b1;
        while (n_acc < 4 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (in_ready) begin
                acc_t[n_acc] = cyc;
                n_acc++;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("stream accepts", 32'(n_acc), 32'd4);
        for (int k = 1; k < 4; k++) begin
            check("stream gap", 32'(acc_t[k] - acc_t[k-1]), 32'(STREAM_GAP));
        end
        wait_done(lat);
        check("stream res", res, 32'h40400000);
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
